// File: rtl/prog_loader.sv
// Boot-time program loader for the TTM4 core: takes a framed byte stream
// (count, low/high byte pairs, checksum) and writes 15-bit words into program memory.
module prog_loader (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic        WR_EN,
    output logic [7:0]  WR_ADDR,
    output logic [14:0] WR_DATA,
    output logic        CPU_RST,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LO,
        S_HI,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [8:0]  remaining;
    logic [7:0]  address;
    logic [7:0]  sum;
    logic [7:0]  lo_byte;
    logic [7:0]  sum_next;
    logic        xfer;
    logic        session_start;

    assign xfer          = RX_VALID & RX_READY;
    assign sum_next      = sum + RX_DATA;
    assign session_start = START & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (START) next_state = S_LEN;
            end
            S_LEN: begin
                if (xfer) next_state = S_LO;
            end
            S_LO: begin
                if (xfer) next_state = S_HI;
            end
            S_HI: begin
                if (xfer) next_state = S_WRITE;
            end
            S_WRITE: begin
                // remaining still holds the pre-decrement count here
                next_state = (remaining == 9'd1) ? S_CSUM : S_LO;
            end
            S_CSUM: begin
                if (xfer) next_state = (sum_next == 8'h00) ? S_DONE : S_ERROR;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            RX_READY <= 1'b0;
            WR_EN    <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            CPU_RST  <= 1'b1;
        end else begin
            state    <= next_state;
            RX_READY <= (next_state == S_LEN) | (next_state == S_LO) |
                        (next_state == S_HI)  | (next_state == S_CSUM);
            WR_EN    <= (next_state == S_WRITE);
            BUSY     <= (next_state == S_LEN)   | (next_state == S_LO)   |
                        (next_state == S_HI)    | (next_state == S_WRITE) |
                        (next_state == S_CSUM);
            DONE     <= (next_state == S_DONE);
            ERR      <= (next_state == S_ERROR);
            CPU_RST  <= (next_state != S_DONE);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            remaining <= 9'd0;
            address   <= 8'h00;
            sum       <= 8'h00;
            lo_byte   <= 8'h00;
            WR_ADDR   <= 8'h00;
            WR_DATA   <= 15'd0;
        end else if (session_start) begin
            sum     <= 8'h00;
            address <= 8'h00;
        end else begin
            case (state)
                S_LEN: begin
                    if (xfer) begin
                        remaining <= (RX_DATA == 8'h00) ? 9'd256 : {1'b0, RX_DATA};
                        sum       <= sum_next;
                    end
                end
                S_LO: begin
                    if (xfer) begin
                        lo_byte <= RX_DATA;
                        sum     <= sum_next;
                    end
                end
                S_HI: begin
                    // The high byte's MSB only contributes to the checksum.
                    if (xfer) begin
                        WR_DATA <= {RX_DATA[6:0], lo_byte};
                        WR_ADDR <= address;
                        sum     <= sum_next;
                    end
                end
                S_WRITE: begin
                    address   <= address + 8'h01;
                    remaining <= remaining - 9'd1;
                end
                S_CSUM: begin
                    if (xfer) sum <= sum_next;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: drives framed byte streams and checks
// every memory write against a queue of expected (address, word) pairs.
module tb_prog_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        WR_EN;
    logic [7:0]  WR_ADDR;
    logic [14:0] WR_DATA;
    logic        CPU_RST;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int          assertCount = 0;
    int          failCount   = 0;
    int          cycle       = 0;
    int          lastWriteCycle = -1;
    bit          spacingCheck = 1'b0;
    logic [7:0]  expAddr = 8'h00;
    logic [22:0] expQ[$];
    logic [7:0]  progLo[256];
    logic [7:0]  progHi[256];

    prog_loader dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .WR_EN    (WR_EN),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .CPU_RST  (CPU_RST),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Scoreboard side: every write strobe must match the oldest expected write.
    always @(negedge CLK) begin
        if (WR_EN === 1'b1) begin
            checkOutput("rx_ready_in_write", {31'd0, RX_READY}, 32'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", 32'd1, 32'd0);
            end else begin
                logic [22:0] e;
                e = expQ.pop_front();
                checkOutput("wr_addr", {24'd0, WR_ADDR}, {24'd0, e[22:15]});
                checkOutput("wr_data", {17'd0, WR_DATA}, {17'd0, e[14:0]});
            end
            if (spacingCheck && lastWriteCycle >= 0)
                checkOutput("write_spacing", cycle - lastWriteCycle, 32'd3);
            lastWriteCycle = cycle;
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input bit gaps);
        int waitCycles;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                RX_VALID = 1'b0;
                RX_DATA  = 8'($urandom);
                @(posedge CLK); #1;
            end
        end
        RX_DATA  = b;
        RX_VALID = 1'b1;
        waitCycles = 0;
        while (RX_READY !== 1'b1 && waitCycles < 50) begin
            @(posedge CLK); #1;
            waitCycles++;
        end
        if (RX_READY !== 1'b1) begin
            checkOutput("rx_ready_timeout", {31'd0, RX_READY}, 32'd1);
        end else begin
            @(posedge CLK); #1;
        end
        RX_VALID = 1'b0;
    endtask

    task automatic startPulse();
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        expAddr = 8'h00;
        lastWriteCycle = -1;
        checkOutput("start_rx_ready", {31'd0, RX_READY}, 32'd1);
        checkOutput("start_busy",     {31'd0, BUSY},     32'd1);
        checkOutput("start_cpu_rst",  {31'd0, CPU_RST},  32'd1);
        checkOutput("start_done",     {31'd0, DONE},     32'd0);
        checkOutput("start_err",      {31'd0, ERR},      32'd0);
    endtask

    task automatic sendFrame(input int n, input bit corrupt, input bit gaps);
        logic [7:0] sum;
        logic [7:0] hdr;
        logic [7:0] csum;
        hdr = n[7:0];
        sum = hdr;
        applyStimulus(hdr, gaps);
        for (int i = 0; i < n; i++) begin
            applyStimulus(progLo[i], gaps);
            sum = sum + progLo[i];
            expQ.push_back({expAddr, progHi[i][6:0], progLo[i]});
            expAddr = expAddr + 8'h01;
            applyStimulus(progHi[i], gaps);
            sum = sum + progHi[i];
        end
        csum = 8'h00 - sum;
        if (corrupt) csum = csum + 8'h01;
        applyStimulus(csum, gaps);
    endtask

    task automatic checkEnd(input string tag, input bit good);
        checkOutput({tag, "_done"},    {31'd0, DONE},     {31'd0, good});
        checkOutput({tag, "_err"},     {31'd0, ERR},      {31'd0, !good});
        checkOutput({tag, "_cpu_rst"}, {31'd0, CPU_RST},  {31'd0, !good});
        checkOutput({tag, "_busy"},    {31'd0, BUSY},     32'd0);
        checkOutput({tag, "_pending"}, expQ.size(),       32'd0);
    endtask

    task automatic loadGoodProgram();
        progLo[0] = 8'h34; progHi[0] = 8'h12;
        progLo[1] = 8'h78; progHi[1] = 8'h56;
    endtask

    initial begin
        RST      = 1'b1;
        START    = 1'b1;
        RX_VALID = 1'b1;
        RX_DATA  = 8'($urandom);
        repeat (2) begin
            @(posedge CLK); #1;
            RX_DATA = 8'($urandom);
        end
        START    = 1'b0;
        RX_VALID = 1'b0;
        RST      = 1'b0;
        checkOutput("reset_cpu_rst",  {31'd0, CPU_RST},  32'd1);
        checkOutput("reset_rx_ready", {31'd0, RX_READY}, 32'd0);
        checkOutput("reset_wr_en",    {31'd0, WR_EN},    32'd0);
        checkOutput("reset_wr_addr",  {24'd0, WR_ADDR},  32'd0);
        checkOutput("reset_wr_data",  {17'd0, WR_DATA},  32'd0);
        checkOutput("reset_busy",     {31'd0, BUSY},     32'd0);
        checkOutput("reset_done",     {31'd0, DONE},     32'd0);
        checkOutput("reset_err",      {31'd0, ERR},      32'd0);
        @(posedge CLK); #1;

        $display("[TB] good frame");
        loadGoodProgram();
        spacingCheck = 1'b1;
        startPulse();
        sendFrame(2, 1'b0, 1'b0);
        checkEnd("good", 1'b1);

        $display("[TB] bad checksum then good frame");
        startPulse();
        sendFrame(2, 1'b1, 1'b0);
        checkEnd("bad", 1'b0);
        startPulse();
        sendFrame(2, 1'b0, 1'b0);
        checkEnd("after_bad", 1'b1);

        $display("[TB] backpressure");
        spacingCheck = 1'b0;
        startPulse();
        sendFrame(2, 1'b0, 1'b1);
        checkEnd("backpressure", 1'b1);

        $display("[TB] 256-word frame");
        for (int i = 0; i < 256; i++) begin
            progLo[i] = 8'($urandom);
            progHi[i] = 8'($urandom);
        end
        spacingCheck = 1'b1;
        startPulse();
        sendFrame(256, 1'b0, 1'b0);
        checkEnd("n256", 1'b1);

        $display("[TB] reset mid-load and reload");
        loadGoodProgram();
        startPulse();
        applyStimulus(8'h02, 1'b0);
        applyStimulus(progLo[0], 1'b0);
        expQ.push_back({8'h00, progHi[0][6:0], progLo[0]});
        applyStimulus(progHi[0], 1'b0);
        checkOutput("midload_wr_en", {31'd0, WR_EN}, 32'd1);
        @(negedge CLK); #1;
        RST      = 1'b1;
        RX_VALID = 1'b1;
        RX_DATA  = progLo[1];
        @(posedge CLK); #1;
        RST = 1'b0;
        checkOutput("midload_busy",     {31'd0, BUSY},     32'd0);
        checkOutput("midload_cpu_rst",  {31'd0, CPU_RST},  32'd1);
        checkOutput("midload_rx_ready", {31'd0, RX_READY}, 32'd0);
        checkOutput("midload_wr_en",    {31'd0, WR_EN},    32'd0);
        repeat (5) @(posedge CLK);
        #1;
        RX_VALID = 1'b0;
        checkOutput("midload_pending", expQ.size(), 32'd0);
        startPulse();
        sendFrame(2, 1'b0, 1'b0);
        checkEnd("reload", 1'b1);
        startPulse();

        repeat (3) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
